ysyx_22040228_div_ctrl: RTL

//  Issue/sequencing controller between the EX stage and the iterative divider (DIV/DIVU/REM/REMU and W forms).

---
 rtl/ysyx_22040228_div_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040228_div_ctrl.sv
// Issue/sequencing controller between EX and the iterative divider: conditions operands,
// resolves divide-by-zero/overflow locally, launches the divider and buffers one response.
// state  | meaning
// IDLE   | ready for a request
// LAUNCH | one-cycle divider start pulse
// BUSY   | waiting for div_finish, timer running
// RESP   | result buffered, waiting for consumer
// DRAIN  | flushed while divider active, discard its result
module ysyx_22040228_div_ctrl #(
  parameter int DIV_TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        stall,
  output logic        err_timeout,
  output logic        div_ready,
  output logic [63:0] dividend,
  output logic [63:0] diviser,
  output logic [7:0]  inst_opcode,
  input  logic [63:0] div_rem_data,
  input  logic        div_finish
);

  localparam logic [7:0] INST_DIV   = 8'h28;
  localparam logic [7:0] INST_DIVU  = 8'h29;
  localparam logic [7:0] INST_REM   = 8'h2A;
  localparam logic [7:0] INST_REMU  = 8'h2B;
  localparam logic [7:0] INST_DIVW  = 8'h2C;
  localparam logic [7:0] INST_DIVUW = 8'h2D;
  localparam logic [7:0] INST_REMW  = 8'h2E;
  localparam logic [7:0] INST_REMUW = 8'h2F;
  localparam int TW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_RESP, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_opcode;
  logic [63:0]   r_dividend, r_diviser, r_resp_data;
  logic          r_err;
  logic [TW-1:0] r_timer;

  logic        w_accept, w_capture, w_timeout, w_timer_clr, w_timer_inc;
  logic        w_legal, w_is_w, w_is_sw, w_is_uw, w_is_rem, w_r_is_w;
  logic        w_div0, w_ovf, w_special, w_timer_hit;
  logic [63:0] w_op1, w_op2, w_spec_raw, w_spec_res;

  // Request decode and operand conditioning
  assign w_is_sw  = (req_opcode == INST_DIVW)  || (req_opcode == INST_REMW);
  assign w_is_uw  = (req_opcode == INST_DIVUW) || (req_opcode == INST_REMUW);
  assign w_is_w   = w_is_sw || w_is_uw;
  assign w_is_rem = (req_opcode == INST_REM)  || (req_opcode == INST_REMU) ||
                    (req_opcode == INST_REMW) || (req_opcode == INST_REMUW);
  assign w_legal  = w_is_w || w_is_rem || (req_opcode == INST_DIV) || (req_opcode == INST_DIVU);

  assign w_op1 = w_is_sw ? {{32{req_src1[31]}}, req_src1[31:0]} :
                 w_is_uw ? {32'b0, req_src1[31:0]} : req_src1;
  assign w_op2 = w_is_sw ? {{32{req_src2[31]}}, req_src2[31:0]} :
                 w_is_uw ? {32'b0, req_src2[31:0]} : req_src2;

  assign w_div0 = w_is_w ? (w_op2[31:0] == 32'b0) : (w_op2 == 64'b0);
  assign w_ovf  = (((req_opcode == INST_DIV) || (req_opcode == INST_REM)) &&
                   (w_op1 == 64'h8000_0000_0000_0000) && (w_op2 == '1)) ||
                  (w_is_sw && (w_op1[31:0] == 32'h8000_0000) && (w_op2[31:0] == 32'hFFFF_FFFF));
  assign w_special = w_legal && (w_div0 || w_ovf);

  always_comb begin
    w_spec_raw = 64'b0;
    if (w_div0)     w_spec_raw = w_is_rem ? w_op1 : '1;
    else if (w_ovf) w_spec_raw = w_is_rem ? 64'b0 : w_op1;
  end
  assign w_spec_res = w_is_w ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;

  assign w_r_is_w    = (r_opcode == INST_DIVW) || (r_opcode == INST_DIVUW) ||
                       (r_opcode == INST_REMW) || (r_opcode == INST_REMUW);
  assign w_timer_hit = (r_timer == TW'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    div_ready   = 1'b0;
    stall       = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = rst;
        stall     = 1'b0;
        if (!flush && req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_special || !w_legal) ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        div_ready   = 1'b1;
        w_timer_clr = 1'b1;
        w_state_nxt = flush ? S_DRAIN : S_BUSY;
      end
      S_BUSY: begin
        if (div_finish) begin
          w_capture   = !flush;
          w_state_nxt = flush ? S_IDLE : S_RESP;
        end else if (w_timer_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = flush ? S_IDLE : S_RESP;
        end else begin
          w_timer_inc = 1'b1;
          w_state_nxt = flush ? S_DRAIN : S_BUSY;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (div_finish) begin
          w_state_nxt = S_IDLE;
        end else if (w_timer_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opcode    <= 8'b0;
      r_dividend  <= 64'b0;
      r_diviser   <= 64'b0;
      r_resp_data <= 64'b0;
      r_err       <= 1'b0;
      r_timer     <= '0;
    end else begin
      if (w_accept) begin
        r_opcode   <= req_opcode;
        r_dividend <= w_op1;
        r_diviser  <= w_op2;
        if (w_special)     r_resp_data <= w_spec_res;
        else if (!w_legal) r_resp_data <= 64'b0;
      end
      if (w_capture)
        r_resp_data <= w_r_is_w ? {{32{div_rem_data[31]}}, div_rem_data[31:0]} : div_rem_data;
      if (w_timeout) begin
        r_err       <= 1'b1;
        r_resp_data <= 64'b0;
      end
      if (w_timer_clr)      r_timer <= '0;
      else if (w_timer_inc) r_timer <= r_timer + TW'(1);
    end
  end

  assign resp_data   = r_resp_data;
  assign err_timeout = r_err;
  assign dividend    = r_dividend;
  assign diviser     = r_diviser;
  assign inst_opcode = r_opcode;

endmodule
